ascii_rom_arbiter: RTL and testbench
====================================

// Module: ascii_rom_arbiter
// PURPOSE
//  Shares one ascii_rom read port (11-bit addr {char[6:0],row[3:0]}, 8-bit data, 1-cycle registered read)
//  among NREQ text generators (win/lose banner, timer, score). Selects one requester per clock, drives the
//  ROM address, and returns the ROM word tagged with the requester id. Sits between the pixel text
//  generators and the single ascii_rom instance in the top level.
// PARAMETERS
//  NREQ   3    number of requesters, 1..8
//  IDW    3    width of rid; must satisfy 2**IDW >= NREQ
// PORTS
//  clk       in   1         system pixel clock
//  reset     in   1         synchronous, active-high
//  req       in   NREQ      req[i]=1: requester i wants a ROM read; held until gnt[i]
//  addr_in   in   NREQ*11   requester i address at bits [i*11 +: 11]
//  gnt       out  NREQ      one-hot or zero; combinational; gnt[i]=1 means addr_in[i] is taken this cycle
//  rom_addr  out  11        to ascii_rom.addr; registered
//  rom_data  in   8         from ascii_rom.data
//  rvalid    out  1         rdata/rid valid this cycle
//  rid       out  IDW       index of the requester that owns rdata
//  rdata     out  8         ROM word; 8'h00 whenever rvalid=0
// BEHAVIOUR
//  - Reset: gnt=0 (forced low while reset=1), rom_addr=11'h000, rvalid=0, rid=0, rdata=0, RR pointer=0.
//  - Grant: when at least one req bit is set, exactly one gnt bit is set in the same cycle. Otherwise gnt=0.
//  - Pipeline, with a grant to requester k in cycle t:
//    - Edge end of t: rom_addr <= addr_in[k]; stage-1 valid and id registered.
//    - Edge end of t+1: the ROM registers data; stage-2 valid and id registered.
//    - Cycle t+2: rvalid=1, rid=k, rdata=rom_data. Fixed latency 2; throughput 1 read per clock.
//  - No grant: rom_addr holds its value; a bubble propagates and rvalid=0 two cycles later.
//  - A requester dropping req before gnt is legal and causes no state change.
//    A requester holding req after gnt issues a new read each cycle it wins.
//  - All requests simultaneous: resolved per CONFIGURATION; the losers keep req asserted and lose nothing.
//  - Reset mid-operation: in-flight reads are discarded. rvalid=0 from the first cycle after the reset edge.
//  - NREQ=1: gnt[0]=req[0]; arbitration logic degenerates.
// CONFIGURATION
//  Macro ROM_ARB_ROUND_ROBIN_EN
//  - Defined: round-robin arbitration.
//    - Pointer p = (last granted index + 1) mod NREQ, updated only on a grant; wraps from NREQ-1 to 0.
//    - Search order is p, p+1, ..., wrapping through the non-power-of-2 NREQ.
//    - No requester waits more than NREQ-1 grants.
//  - Undefined: fixed priority; the lowest index wins. No pointer register exists.
// STRUCTURE
//  - Package rom_arb_pkg: ROM_AW=11, ROM_DW=8, CHAR_AW=7, ROW_AW=4, and function rom_addr_f(char,row)={char,row}.
//  - Sub-module rom_arb_sel: a masked priority encoder, req + pointer -> one-hot gnt plus index.
//    With ROM_ARB_ROUND_ROBIN_EN undefined, the pointer is tied to 0.
//  - Top level: rom_arb_sel, address mux/register, 2-stage valid/id shift register, and rdata gating.
// TESTING (bench uses a behavioural ascii_rom model with 1-cycle read latency)
//  1. Reset held 3 cycles with req=3'b111 -> gnt=0, rvalid=0 and rom_addr=0 throughout; rvalid=0 on the first post-reset cycle.
//  2. Single req[1] with addr 11'h573 ('W', row 3) in cycle t -> gnt=3'b010 at t;
//     rvalid=1, rid=1, rdata=ROM[0x573] at t+2; rvalid=0 at t+3.
//  3. req=3'b111 held 6 cycles:
//     - Fixed priority: gnt=001 every cycle, rid=0 stream.
//     - Round-robin: gnt 001,010,100,001,010,100; rid 0,1,2,0,1,2 starting 2 cycles later.
//  4. Back-to-back: req[2] held 4 cycles with addresses 0x490,0x491,0x492,0x493 ('I', rows 0-3)
//     -> 4 consecutive rvalid cycles with matching ROM data and no bubbles.
//  5. Reset asserted one cycle after a grant -> no rvalid for that read; RR pointer restarts at 0 (next winner with 111 is 0).
//  6. Idle gap: req=0 for 5 cycles between grants -> rom_addr unchanged during the gap; rvalid=0 and rdata=0 exactly 2 cycles after gap start.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared ROM geometry and address helper for the ascii_rom arbiter.
package rom_arb_pkg;

  localparam int unsigned ROM_AW  = 11;
  localparam int unsigned ROM_DW  = 8;
  localparam int unsigned CHAR_AW = 7;
  localparam int unsigned ROW_AW  = 4;

  // ROM address is the character code followed by the glyph row.
  function automatic logic [ROM_AW-1:0] rom_addr_f(input logic [CHAR_AW-1:0] ch,
                                                   input logic [ROW_AW-1:0]  row);
    return {ch, row};
  endfunction

endpackage

// File: rtl/rom_arb_sel.sv
// Masked priority encoder: picks the first requester at or after ptr_i,
// wrapping modulo NREQ. Returns a one-hot grant and the winning index.
module rom_arb_sel
  import rom_arb_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IDW  = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  localparam int unsigned SW = IDW + 1;

  logic [2*NREQ-1:0] req2;
  logic [NREQ-1:0]   rot;
  logic [IDW-1:0]    off;
  logic [SW-1:0]     sum;

  // Rotate requests so the pointer position is bit 0, find lowest set bit, un-rotate.
  always_comb begin
    req2  = {req_i, req_i};
    rot   = NREQ'(req2 >> ptr_i);
    off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDW'(i);
    end
    sum = SW'(ptr_i) + SW'(off);
    if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
    idx_o = IDW'(sum);
    any_o = |req_i;
    gnt_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_o[i] = any_o && (idx_o == IDW'(i));
    end
  end

endmodule

// File: rtl/ascii_rom_arbiter.sv
// Shares one ascii_rom read port among NREQ text generators.
// Build option: ROM_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it the lowest requesting index wins.
module ascii_rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IDW  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ROM_AW-1:0] addr_in,
  output logic [NREQ-1:0]        gnt,
  output logic [ROM_AW-1:0]      rom_addr,
  input  logic [ROM_DW-1:0]      rom_data,
  output logic                   rvalid,
  output logic [IDW-1:0]         rid,
  output logic [ROM_DW-1:0]      rdata
);

  logic [NREQ-1:0]   gnt_raw;
  logic [IDW-1:0]    win_idx;
  logic              win_any;
  logic [IDW-1:0]    ptr;
  logic              grant;
  logic [ROM_AW-1:0] addr_mux;

  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              s1_vld_q, s1_vld_d;
  logic [IDW-1:0]    s1_id_q, s1_id_d;
  logic              s2_vld_q, s2_vld_d;
  logic [IDW-1:0]    s2_id_q, s2_id_d;

  rom_arb_sel #(.NREQ(NREQ), .IDW(IDW)) u_sel (
    .req_i (req),
    .ptr_i (ptr),
    .gnt_o (gnt_raw),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // Grants are suppressed while reset is asserted.
  assign gnt   = reset ? '0 : gnt_raw;
  assign grant = win_any && !reset;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  // Pointer moves to the slot after the last winner, only when a grant happens.
  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // Address mux from the one-hot grant.
  always_comb begin
    addr_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_raw[i]) addr_mux = addr_in[i*ROM_AW +: ROM_AW];
    end
  end

  // Next state: address holds on bubbles, valid/id shift two stages behind the grant.
  always_comb begin
    rom_addr_d = rom_addr_q;
    if (grant) rom_addr_d = addr_mux;
    s1_vld_d = grant;
    s1_id_d  = grant ? win_idx : '0;
    s2_vld_d = s1_vld_q;
    s2_id_d  = s1_id_q;
  end

  // Pipeline registers; reset discards in-flight reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_id_q    <= '0;
      s2_vld_q   <= 1'b0;
      s2_id_q    <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      s1_vld_q   <= s1_vld_d;
      s1_id_q    <= s1_id_d;
      s2_vld_q   <= s2_vld_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign rvalid   = s2_vld_q;
  assign rid      = s2_id_q;
  assign rdata    = s2_vld_q ? rom_data : '0;

endmodule

// File: tb/tb_ascii_rom_arbiter.sv
// Directed table-driven bench for ascii_rom_arbiter with a 1-cycle ROM model.
module tb_ascii_rom_arbiter;
  import rom_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [32:0] addr_in;
  logic [2:0]  gnt;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rvalid;
  logic [2:0]  rid;
  logic [7:0]  rdata;

  int checks   = 0;
  int failures = 0;
  int cur_step = 0;

  always #5 clk = ~clk;

  ascii_rom_arbiter #(.NREQ(3), .IDW(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .addr_in  (addr_in),
    .gnt      (gnt),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rvalid   (rvalid),
    .rid      (rid),
    .rdata    (rdata)
  );

  function automatic logic [7:0] rom_f(input logic [10:0] a);
    return a[7:0] ^ {a[10:8], a[10:6]};
  endfunction

  // Behavioural ascii_rom: registered read.
  always @(posedge clk) rom_data <= rom_f(rom_addr);

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [10:0] a0, a1, a2;
    logic [2:0]  egnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic [2:0] r, input logic [10:0] a0,
                     input logic [10:0] a1, input logic [10:0] a2, input logic [2:0] eg);
    vec_t v;
    v.rst = rst; v.req = r; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.egnt = eg;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h exp=%h", nm, cur_step, act, exp);
    end
  endtask

  // Scoreboard state: expected rom_addr and two-stage valid/id/addr pipeline.
  logic [10:0] m_addr;
  logic        m_s1v, m_s2v;
  logic [2:0]  m_s1id, m_s2id;
  logic [10:0] m_s1a, m_s2a;

  initial begin
    logic [10:0] A_W3, AI0, AI1, AI2, AI3, P0, P1, P2;
    logic [2:0]  rr [6];
    logic [10:0] ka;
    logic [2:0]  k;

    A_W3 = rom_addr_f(7'h57, 4'h3);
    AI0  = rom_addr_f(7'h49, 4'h0);
    AI1  = rom_addr_f(7'h49, 4'h1);
    AI2  = rom_addr_f(7'h49, 4'h2);
    AI3  = rom_addr_f(7'h49, 4'h3);
    P0 = 11'h410; P1 = 11'h421; P2 = 11'h432;
`ifdef ROM_ARB_ROUND_ROBIN_EN
    rr[0] = 3'b001; rr[1] = 3'b010; rr[2] = 3'b100;
    rr[3] = 3'b001; rr[4] = 3'b010; rr[5] = 3'b100;
`else
    for (int i = 0; i < 6; i++) rr[i] = 3'b001;
`endif

    // 1: reset held with all requests pending.
    for (int i = 0; i < 3; i++) add(1, 3'b111, P0, P1, P2, 3'b000);
    // 2: single read by requester 1 at 'W' row 3.
    add(0, 3'b010, 11'h000, A_W3, 11'h000, 3'b010);
    for (int i = 0; i < 3; i++) add(0, 3'b000, 0, 0, 0, 3'b000);
    // 3: all requesting for 6 cycles from a fresh pointer.
    add(1, 3'b000, 0, 0, 0, 3'b000);
    for (int i = 0; i < 6; i++) add(0, 3'b111, P0, P1, P2, rr[i]);
    add(0, 3'b000, 0, 0, 0, 3'b000);
    add(0, 3'b000, 0, 0, 0, 3'b000);
    // 4: back-to-back reads of 'I' rows 0-3 by requester 2.
    add(0, 3'b100, 0, 0, AI0, 3'b100);
    add(0, 3'b100, 0, 0, AI1, 3'b100);
    add(0, 3'b100, 0, 0, AI2, 3'b100);
    add(0, 3'b100, 0, 0, AI3, 3'b100);
    add(0, 3'b000, 0, 0, 0, 3'b000);
    add(0, 3'b000, 0, 0, 0, 3'b000);
    // 5: reset one cycle after a grant, then pointer restarts at 0.
    add(0, 3'b111, P0, P1, P2, 3'b001);
    add(1, 3'b111, P0, P1, P2, 3'b000);
    add(0, 3'b111, P0, P1, P2, 3'b001);
    add(0, 3'b000, 0, 0, 0, 3'b000);
    add(0, 3'b000, 0, 0, 0, 3'b000);
    // 6: idle gap of 5 cycles between grants.
    add(0, 3'b001, 11'h155, 0, 0, 3'b001);
    for (int i = 0; i < 5; i++) add(0, 3'b000, 11'h7FF, 11'h7FF, 11'h7FF, 3'b000);
    add(0, 3'b010, 0, 11'h2AA, 0, 3'b010);
    for (int i = 0; i < 3; i++) add(0, 3'b000, 0, 0, 0, 3'b000);

    m_addr = '0; m_s1v = 0; m_s2v = 0; m_s1id = '0; m_s2id = '0; m_s1a = '0; m_s2a = '0;
    reset = 1'b1; req = 3'b111; addr_in = '0;
    repeat (2) @(posedge clk);

    for (int n = 0; n < vq.size(); n++) begin
      cur_step = n;
      @(negedge clk);
      chk("rom_addr", 32'(rom_addr), 32'(m_addr));
      chk("rvalid", 32'(rvalid), 32'(m_s2v));
      chk("rid", 32'(rid), 32'(m_s2id));
      chk("rdata", 32'(rdata), m_s2v ? 32'(rom_f(m_s2a)) : 32'd0);
      reset   = vq[n].rst;
      req     = vq[n].req;
      addr_in = {vq[n].a2, vq[n].a1, vq[n].a0};
      #1;
      chk("gnt", 32'(gnt), 32'(vq[n].egnt));
      if (vq[n].rst) begin
        m_addr = '0; m_s1v = 0; m_s2v = 0; m_s1id = '0; m_s2id = '0;
      end else begin
        m_s2v = m_s1v; m_s2id = m_s1id; m_s2a = m_s1a;
        k  = vq[n].egnt[0] ? 3'd0 : (vq[n].egnt[1] ? 3'd1 : 3'd2);
        ka = (k == 3'd0) ? vq[n].a0 : ((k == 3'd1) ? vq[n].a1 : vq[n].a2);
        m_s1v  = |vq[n].egnt;
        m_s1id = m_s1v ? k : 3'd0;
        if (m_s1v) begin
          m_s1a  = ka;
          m_addr = ka;
        end
      end
    end

    // Hand sequence: reset lands while a read sits in stage 2, not stage 1.
    cur_step = 1000;
    @(negedge clk);
    reset = 1'b0; req = 3'b001; addr_in = {11'h0, 11'h0, 11'h7F0};
    @(negedge clk);
    req = 3'b000;
    @(negedge clk);
    reset = 1'b1; req = 3'b011;
    #1 chk("gnt_in_reset", 32'(gnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cur_step = 1001 + i;
      chk("rvalid_after_reset", 32'(rvalid), 32'd0);
      chk("rdata_after_reset", 32'(rdata), 32'd0);
      chk("rom_addr_after_reset", 32'(rom_addr), 32'd0);
    end
    reset = 1'b0; req = 3'b110; addr_in = {11'h333, 11'h222, 11'h111};
    #1 chk("gnt_after_release", 32'(gnt), 32'b010);
    @(negedge clk);
    chk("rom_addr_after_release", 32'(rom_addr), 32'h222);
    req = 3'b000;
    @(negedge clk);
    chk("rvalid_hand", 32'(rvalid), 32'd1);
    chk("rid_hand", 32'(rid), 32'd1);
    chk("rdata_hand", 32'(rdata), 32'(rom_f(11'h222)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
